// File: rtl/fpga_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fpga_pkg
// Brief    : Shared state encoding and firstBad "none" helper for out_checker.
// Revision : 1.0
// ============================================================================
package fpga_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // firstBad reports the table depth itself when no mismatch has been seen.
  function automatic int unsigned first_bad_none(input int unsigned n_expected);
    return n_expected;
  endfunction

endpackage
`default_nettype wire

// File: rtl/out_checker_table.sv
`default_nettype none
// ============================================================================
// Module   : out_checker_table
// Brief    : Expected-word table, synchronous write and combinational read.
// Revision : 1.0
// ============================================================================
module out_checker_table #(
  parameter int Width = 12,
  parameter int Depth = 8
) (
  input  logic                     clock,
  input  logic                     we_i,
  input  logic [$clog2(Depth)-1:0] waddr_i,
  input  logic [Width-1:0]         wdata_i,
  input  logic [$clog2(Depth)-1:0] raddr_i,
  output logic [Width-1:0]         rdata_o
);

  logic [Width-1:0] mem_q [Depth];

  always_ff @(posedge clock) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule
`default_nettype wire

// File: rtl/out_checker.sv
`default_nettype none
// ============================================================================
// Module   : out_checker
// Brief    : Compares a producer's out-channel stream against a loaded table.
//            Optional idle timeout enabled by defining OUT_CHECKER_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
module out_checker
  import fpga_pkg::*;
#(
  parameter int MemoryElementWidth = 12,
  parameter int NExpected          = 8,
  parameter int Timeout            = 64
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          load,
  input  logic [$clog2(NExpected)-1:0]  loadIndex,
  input  logic [MemoryElementWidth-1:0] loadData,
  input  logic [$clog2(NExpected):0]    expectCount,
  input  logic                          start,
  input  logic                          outValid,
  input  logic [MemoryElementWidth-1:0] outData,
  output logic                          outReady,
  input  logic                          programFinished,
  output logic                          finished,
  output logic                          success,
  output logic [$clog2(NExpected):0]    received,
  output logic [$clog2(NExpected):0]    firstBad
);

  localparam int AW = $clog2(NExpected);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] c_NONE = CW'(first_bad_none(NExpected));
  localparam logic [CW-1:0] c_NEXP = CW'(NExpected);
  localparam logic [CW-1:0] c_SAT  = {CW{1'b1}};

  state_e                  state_q;
  logic [CW-1:0]           count_q;
  logic [CW-1:0]           received_q;
  logic [CW-1:0]           received_d;
  logic [CW-1:0]           first_bad_q;
  logic [CW-1:0]           first_bad_d;
  logic                    finished_q;
  logic                    success_q;
  logic [MemoryElementWidth-1:0] w_expected;
  logic                    w_accept;
  logic                    w_mismatch;
  logic                    w_timeout;

  out_checker_table #(
    .Width (MemoryElementWidth),
    .Depth (NExpected)
  ) u_table (
    .clock   (clock),
    .we_i    (load && (state_q == ST_IDLE)),
    .waddr_i (loadIndex),
    .wdata_i (loadData),
    .raddr_i (received_q[AW-1:0]),
    .rdata_o (w_expected)
  );

  // Words beyond the latched count are overflow and always count as bad.
  always_comb begin
    w_accept    = (state_q == ST_CHECK) && outValid;
    w_mismatch  = (received_q >= count_q) || (w_expected != outData);
    received_d  = received_q;
    first_bad_d = first_bad_q;
    if (w_accept) begin
      if (received_q != c_SAT) begin
        received_d = received_q + CW'(1);
      end
      if (w_mismatch && (first_bad_q == c_NONE)) begin
        first_bad_d = received_q;
      end
    end
  end

`ifdef OUT_CHECKER_TIMEOUT_EN
  localparam int TW = $clog2(Timeout + 1);
  logic [TW-1:0] idle_q;

  assign w_timeout = (state_q == ST_CHECK) && !w_accept && (idle_q == TW'(Timeout - 1));

  always_ff @(posedge clock) begin
    if (!reset) begin
      idle_q <= '0;
    end else if ((state_q != ST_CHECK) || w_accept) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_q + TW'(1);
    end
  end
`else
  assign w_timeout = 1'b0 & (Timeout > 0);
`endif

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      received_q  <= '0;
      first_bad_q <= c_NONE;
      finished_q  <= 1'b0;
      success_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_q     <= ST_CHECK;
            count_q     <= (expectCount > c_NEXP) ? c_NEXP : expectCount;
            received_q  <= '0;
            first_bad_q <= c_NONE;
            finished_q  <= 1'b0;
            success_q   <= 1'b0;
          end
        end
        ST_CHECK: begin
          received_q  <= received_d;
          first_bad_q <= first_bad_d;
          if (programFinished || w_timeout) begin
            state_q    <= ST_DONE;
            finished_q <= 1'b1;
            success_q  <= programFinished && (received_d == count_q)
                          && (first_bad_d == c_NONE);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign outReady = (state_q == ST_CHECK);
  assign finished = finished_q;
  assign success  = success_q;
  assign received = received_q;
  assign firstBad = first_bad_q;

endmodule
`default_nettype wire

// File: tb/tb_out_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_out_checker
// Brief    : Directed self-checking bench for out_checker (default parameters).
// Revision : 1.0
// ============================================================================
module tb_out_checker;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        load = 1'b0;
  logic [2:0]  loadIndex = '0;
  logic [11:0] loadData = '0;
  logic [3:0]  expectCount = '0;
  logic        start = 1'b0;
  logic        outValid = 1'b0;
  logic [11:0] outData = '0;
  logic        outReady;
  logic        programFinished = 1'b0;
  logic        finished;
  logic        success;
  logic [3:0]  received;
  logic [3:0]  firstBad;

  int checks = 0;
  int errors = 0;

  out_checker dut (
    .clock           (clock),
    .reset           (reset),
    .load            (load),
    .loadIndex       (loadIndex),
    .loadData        (loadData),
    .expectCount     (expectCount),
    .start           (start),
    .outValid        (outValid),
    .outData         (outData),
    .outReady        (outReady),
    .programFinished (programFinished),
    .finished        (finished),
    .success         (success),
    .received        (received),
    .firstBad        (firstBad)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load_word(input logic [2:0] idx, input logic [11:0] val);
    load      = 1'b1;
    loadIndex = idx;
    loadData  = val;
    tick();
    load      = 1'b0;
  endtask

  task automatic load3(input logic [11:0] a, input logic [11:0] b, input logic [11:0] c);
    load_word(3'd0, a);
    load_word(3'd1, b);
    load_word(3'd2, c);
  endtask

  task automatic start_check(input logic [3:0] cnt);
    expectCount = cnt;
    start       = 1'b1;
    tick();
    start       = 1'b0;
  endtask

  task automatic send(input logic [11:0] w);
    outValid = 1'b1;
    outData  = w;
    tick();
    outValid = 1'b0;
  endtask

  task automatic finish_prog();
    programFinished = 1'b1;
    tick();
    programFinished = 1'b0;
  endtask

  task automatic check_result(input string name, input logic exp_succ,
                              input logic [3:0] exp_rcv, input logic [3:0] exp_bad);
    checks++;
    if (finished !== 1'b1) begin
      errors++;
      $display("FAIL %s finished: got %0d expected 1", name, finished);
    end
    checks++;
    if (success !== exp_succ) begin
      errors++;
      $display("FAIL %s success: got %0d expected %0d", name, success, exp_succ);
    end
    checks++;
    if (received !== exp_rcv) begin
      errors++;
      $display("FAIL %s received: got %0d expected %0d", name, received, exp_rcv);
    end
    checks++;
    if (firstBad !== exp_bad) begin
      errors++;
      $display("FAIL %s firstBad: got %0d expected %0d", name, firstBad, exp_bad);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    checks++;
    if (outReady !== 1'b0) begin errors++; $display("FAIL reset outReady: got %0d expected 0", outReady); end
    checks++;
    if (finished !== 1'b0) begin errors++; $display("FAIL reset finished: got %0d expected 0", finished); end
    checks++;
    if (success !== 1'b0) begin errors++; $display("FAIL reset success: got %0d expected 0", success); end
    checks++;
    if (received !== 4'd0) begin errors++; $display("FAIL reset received: got %0d expected 0", received); end
    checks++;
    if (firstBad !== 4'd8) begin errors++; $display("FAIL reset firstBad: got %0d expected 8", firstBad); end
  endtask

  task automatic test_match();
    load3(12'd2, 12'd5, 12'd7);
    start_check(4'd3);
    checks++;
    if (outReady !== 1'b1) begin errors++; $display("FAIL match outReady: got %0d expected 1", outReady); end
    send(12'd2);
    send(12'd5);
    send(12'd7);
    checks++;
    if (finished !== 1'b0) begin errors++; $display("FAIL match early finished: got %0d expected 0", finished); end
    finish_prog();
    check_result("match", 1'b1, 4'd3, 4'd8);
    checks++;
    if (outReady !== 1'b0) begin errors++; $display("FAIL done outReady: got %0d expected 0", outReady); end
    // Stray valid words and idle cycles in DONE must not disturb the result.
    outValid = 1'b1;
    outData  = 12'd99;
    tick();
    tick();
    outValid = 1'b0;
    check_result("done_hold", 1'b1, 4'd3, 4'd8);
  endtask

  task automatic test_mismatch();
    start_check(4'd3);
    send(12'd2);
    send(12'd9);
    send(12'd7);
    finish_prog();
    check_result("mismatch", 1'b0, 4'd3, 4'd1);
  endtask

  task automatic test_overflow();
    start_check(4'd2);
    send(12'd2);
    send(12'd5);
    send(12'd7);
    finish_prog();
    check_result("overflow", 1'b0, 4'd3, 4'd2);
    start_check(4'd3);
    send(12'd2);
    send(12'd5);
    finish_prog();
    check_result("underflow", 1'b0, 4'd2, 4'd8);
  endtask

  task automatic test_back_to_back();
    start_check(4'd3);
    send(12'd2);
    tick();
    send(12'd5);
    tick();
    outValid        = 1'b1;
    outData         = 12'd7;
    programFinished = 1'b1;
    tick();
    outValid        = 1'b0;
    programFinished = 1'b0;
    check_result("toggle", 1'b1, 4'd3, 4'd8);
  endtask

  task automatic test_zero_count();
    start_check(4'd0);
    finish_prog();
    check_result("zero", 1'b1, 4'd0, 4'd8);
  endtask

  task automatic test_load_ignored();
    load_word(3'd0, 12'd99);
    start_check(4'd2);
    load_word(3'd1, 12'd77);
    send(12'd2);
    send(12'd5);
    finish_prog();
    check_result("load_ignored", 1'b1, 4'd2, 4'd8);
  endtask

  task automatic test_mid_reset();
    start_check(4'd3);
    send(12'd2);
    checks++;
    if (received !== 4'd1) begin errors++; $display("FAIL midreset pre received: got %0d expected 1", received); end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    checks++;
    if (outReady !== 1'b0) begin errors++; $display("FAIL midreset outReady: got %0d expected 0", outReady); end
    checks++;
    if (received !== 4'd0) begin errors++; $display("FAIL midreset received: got %0d expected 0", received); end
    checks++;
    if (finished !== 1'b0) begin errors++; $display("FAIL midreset finished: got %0d expected 0", finished); end
    tick();
    checks++;
    if (finished !== 1'b0) begin errors++; $display("FAIL midreset late finished: got %0d expected 0", finished); end
    load3(12'd2, 12'd5, 12'd7);
    start_check(4'd3);
    send(12'd2);
    send(12'd5);
    send(12'd7);
    finish_prog();
    check_result("restart", 1'b1, 4'd3, 4'd8);
  endtask

  task automatic test_clamp();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      load_word(3'(i), 12'(100 + i));
    end
    start_check(4'd15);
    for (int i = 0; i < 8; i++) begin
      send(12'(100 + i));
    end
    finish_prog();
    check_result("clamp", 1'b1, 4'd8, 4'd8);
  endtask

  task automatic test_timeout();
    start_check(4'd3);
`ifdef OUT_CHECKER_TIMEOUT_EN
    for (int i = 0; i < 63; i++) begin
      tick();
    end
    checks++;
    if (finished !== 1'b0) begin errors++; $display("FAIL timeout early: got %0d expected 0", finished); end
    tick();
    check_result("timeout", 1'b0, 4'd0, 4'd8);
`else
    for (int i = 0; i < 100; i++) begin
      tick();
    end
    checks++;
    if (finished !== 1'b0) begin errors++; $display("FAIL no_timeout finished: got %0d expected 0", finished); end
    checks++;
    if (outReady !== 1'b1) begin errors++; $display("FAIL no_timeout outReady: got %0d expected 1", outReady); end
    finish_prog();
    check_result("no_timeout", 1'b0, 4'd0, 4'd8);
`endif
  endtask

  initial begin
    test_reset();
    test_match();
    test_mismatch();
    test_overflow();
    test_back_to_back();
    test_zero_count();
    test_load_ignored();
    test_mid_reset();
    test_clamp();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
